// File: rtl/intersection_controller.sv
// Two-road intersection controller: NS/EW greens with a pedestrian walk phase,
// minimum dwell counters and latched vehicle/pedestrian requests.
module intersection_controller #(
  parameter int unsigned G_TIME    = 4,
  parameter int unsigned Y_TIME    = 1,
  parameter int unsigned AR_TIME   = 1,
  parameter int unsigned WALK_TIME = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CarEW,
  input  logic       PedReq,
  output logic [2:0] NS_RGY,
  output logic [2:0] EW_RGY,
  output logic       Walk,
  output logic       PedPending,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALL_RED_A = 3'd2,
    S_WALK      = 3'd3,
    S_EW_GREEN  = 3'd4,
    S_EW_YELLOW = 3'd5,
    S_ALL_RED_B = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_G  = CNT_W'(G_TIME);
  localparam logic [CNT_W-1:0] L_Y  = CNT_W'(Y_TIME);
  localparam logic [CNT_W-1:0] L_AR = CNT_W'(AR_TIME);
  localparam logic [CNT_W-1:0] L_WK = CNT_W'(WALK_TIME);

  // State register kept as a plain vector so an illegal code (7) is representable.
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_car;
  logic             r_ped;
  logic [2:0]       r_ns;
  logic [2:0]       r_ew;
  logic             r_walk;

  state_t           w_next;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_exp;
  logic             w_enter;

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_NS_GREEN,  S_EW_GREEN:  w_limit = L_G;
      S_NS_YELLOW, S_EW_YELLOW: w_limit = L_Y;
      S_ALL_RED_A, S_ALL_RED_B: w_limit = L_AR;
      S_WALK:                   w_limit = L_WK;
      default:                  w_limit = '0;
    endcase
  end

  assign w_exp = (r_cnt == w_limit);

  always_comb begin
    w_next = S_ALL_RED_B;
    case (r_state)
      S_NS_GREEN:  w_next = (w_exp && (r_car || r_ped)) ? S_NS_YELLOW : S_NS_GREEN;
      S_NS_YELLOW: w_next = w_exp ? S_ALL_RED_A : S_NS_YELLOW;
      S_ALL_RED_A: w_next = !w_exp ? S_ALL_RED_A : (r_ped ? S_WALK : S_EW_GREEN);
      S_WALK:      w_next = !w_exp ? S_WALK : (r_car ? S_EW_GREEN : S_ALL_RED_B);
      S_EW_GREEN:  w_next = w_exp ? S_EW_YELLOW : S_EW_GREEN;
      S_EW_YELLOW: w_next = w_exp ? S_ALL_RED_B : S_EW_YELLOW;
      S_ALL_RED_B: w_next = w_exp ? S_NS_GREEN : S_ALL_RED_B;
      default:     w_next = S_ALL_RED_B;
    endcase
  end

  // Counter restarts on every state entry and saturates while a state is held.
  assign w_enter   = (w_next != r_state);
  assign w_cnt_nxt = w_enter ? '0 : (w_exp ? r_cnt : r_cnt + CNT_W'(1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_NS_GREEN;
      r_cnt   <= '0;
      r_car   <= 1'b0;
      r_ped   <= 1'b0;
      r_ns    <= 3'b010;
      r_ew    <= 3'b100;
      r_walk  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      // Clearing on the entry edge takes priority over a coincident request.
      if (w_next == S_EW_GREEN && r_state != S_EW_GREEN) r_car <= 1'b0;
      else if (CarEW && r_state != S_EW_GREEN)         r_car <= 1'b1;
      if (w_next == S_WALK && r_state != S_WALK)         r_ped <= 1'b0;
      else if (PedReq)                                   r_ped <= 1'b1;
      r_ns   <= (w_next == S_NS_GREEN)  ? 3'b010 :
                (w_next == S_NS_YELLOW) ? 3'b001 : 3'b100;
      r_ew   <= (w_next == S_EW_GREEN)  ? 3'b010 :
                (w_next == S_EW_YELLOW) ? 3'b001 : 3'b100;
      r_walk <= (w_next == S_WALK);
    end
  end

  assign State      = r_state;
  assign NS_RGY     = r_ns;
  assign EW_RGY     = r_ew;
  assign Walk       = r_walk;
  assign PedPending = r_ped;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed timelines plus random traffic against a time-in-state reference model;
// lamp safety (no dual green, all-red before green) is checked every cycle.
module tb_intersection_controller;
  localparam int G_TIME = 4, Y_TIME = 1, AR_TIME = 1, WALK_TIME = 3;

  logic Clock = 1'b0;
  logic Reset, CarEW, PedReq;
  logic [2:0] NS_RGY, EW_RGY, State;
  logic Walk, PedPending;

  int checks = 0;
  int errors = 0;

  int m_st, m_t;
  bit m_car, m_ped;
  bit prev_g;
  int red_run;

  intersection_controller dut (
    .Clock(Clock), .Reset(Reset), .CarEW(CarEW), .PedReq(PedReq),
    .NS_RGY(NS_RGY), .EW_RGY(EW_RGY), .Walk(Walk), .PedPending(PedPending),
    .State(State)
  );

  always #5 Clock = ~Clock;

  function automatic int lim(int s);
    case (s)
      0, 4:    return G_TIME;
      1, 5:    return Y_TIME;
      2, 6:    return AR_TIME;
      3:       return WALK_TIME;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_car = 0; m_ped = 0;
  endtask

  // m_t counts cycles spent in the state without saturating; expiry is t >= limit.
  task automatic model_step(bit car, bit ped);
    int nx;
    bit ex;
    ex = (m_t >= lim(m_st));
    nx = m_st;
    case (m_st)
      0: if (ex && (m_car || m_ped)) nx = 1;
      1: if (ex) nx = 2;
      2: if (ex) nx = m_ped ? 3 : 4;
      3: if (ex) nx = m_car ? 4 : 6;
      4: if (ex) nx = 5;
      5: if (ex) nx = 6;
      6: if (ex) nx = 0;
      default: nx = 6;
    endcase
    if (nx == 4 && m_st != 4) m_car = 0;
    else if (car && m_st != 4) m_car = 1;
    if (nx == 3 && m_st != 3) m_ped = 0;
    else if (ped) m_ped = 1;
    m_t  = (nx != m_st) ? 0 : m_t + 1;
    m_st = nx;
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic safety(bit rst);
    bit g;
    g = NS_RGY[1] | EW_RGY[1];
    chk("dual_green", 8'(NS_RGY[1] & EW_RGY[1]), 8'd0);
    if (rst) begin
      red_run = AR_TIME + 1;
      prev_g  = g;
    end else begin
      if (g && !prev_g) chk("allred_before_green", 8'(red_run >= AR_TIME + 1), 8'd1);
      if (NS_RGY == 3'b100 && EW_RGY == 3'b100) red_run++;
      else red_run = 0;
      prev_g = g;
    end
  endtask

  task automatic compare_all();
    logic [2:0] ns, ew;
    ns = (m_st == 0) ? 3'b010 : (m_st == 1) ? 3'b001 : 3'b100;
    ew = (m_st == 4) ? 3'b010 : (m_st == 5) ? 3'b001 : 3'b100;
    chk("State", 8'(State), 8'(m_st));
    chk("NS_RGY", 8'(NS_RGY), 8'(ns));
    chk("EW_RGY", 8'(EW_RGY), 8'(ew));
    chk("Walk", 8'(Walk), 8'(m_st == 3));
    chk("PedPending", 8'(PedPending), 8'(m_ped));
  endtask

  task automatic step(bit car, bit ped, bit rst);
    CarEW = car; PedReq = ped; Reset = rst;
    @(posedge Clock);
    if (rst) model_reset();
    else model_step(car, ped);
    @(negedge Clock);
    compare_all();
    safety(rst);
  endtask

  // Reset, then pulse the given inputs in cycle 2 and check State against a fixed
  // timeline of (state, length) segments.
  task automatic timeline(string tag, bit car, bit ped, int st[8], int ln[8], int n);
    int c;
    step(0, 0, 1);
    c = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < ln[i]; j++) begin
        chk(tag, 8'(State), 8'(st[i]));
        step(c == 2 ? car : 1'b0, c == 2 ? ped : 1'b0, 0);
        c++;
      end
  endtask

  initial begin
    Reset = 1; CarEW = 0; PedReq = 0;
    prev_g = 0; red_run = AR_TIME + 1;
    model_reset();
    @(negedge Clock);

    // Reset state
    step(1, 1, 1);
    chk("rst_State", 8'(State), 8'd0);
    chk("rst_NS", 8'(NS_RGY), 8'b010);
    chk("rst_EW", 8'(EW_RGY), 8'b100);
    chk("rst_Walk", 8'(Walk), 8'd0);
    chk("rst_Ped", 8'(PedPending), 8'd0);

    timeline("idle_hold", 0, 0, '{0,0,0,0,0,0,0,0}, '{50,0,0,0,0,0,0,0}, 1);
    timeline("car_only",  1, 0, '{0,1,2,4,5,6,0,0}, '{5,2,2,5,2,2,3,0}, 7);
    timeline("ped_only",  0, 1, '{0,1,2,3,6,0,0,0}, '{5,2,2,4,2,3,0,0}, 6);
    timeline("car_ped",   1, 1, '{0,1,2,3,4,5,6,0}, '{5,2,2,4,5,2,2,6}, 8);

    // Reset in the middle of EW_GREEN with a pedestrian request pending.
    step(0, 0, 1);
    step(1, 1, 0);
    for (int k = 0; k < 60 && !(m_st == 4 && m_t == 2); k++) step(0, m_st == 4, 0);
    chk("ewg_cnt2_reached", 8'(m_st == 4 && m_t == 2), 8'd1);
    chk("pre_rst_ped", 8'(PedPending), 8'd1);
    step(1, 1, 1);
    chk("midrst_State", 8'(State), 8'd0);
    chk("midrst_NS", 8'(NS_RGY), 8'b010);
    chk("midrst_EW", 8'(EW_RGY), 8'b100);
    chk("midrst_Ped", 8'(PedPending), 8'd0);
    for (int k = 0; k < 8; k++) step(0, 0, 0);

    // Illegal state code 7 recovers through ALL_RED_B with all lamps red.
    force dut.r_state = 3'd7;
    @(posedge Clock);
    @(negedge Clock);
    chk("ill_NS", 8'(NS_RGY), 8'b100);
    chk("ill_EW", 8'(EW_RGY), 8'b100);
    chk("ill_Walk", 8'(Walk), 8'd0);
    release dut.r_state;
    @(posedge Clock);
    @(negedge Clock);
    chk("ill_State", 8'(State), 8'd6);
    chk("ill_NS2", 8'(NS_RGY), 8'b100);
    chk("ill_EW2", 8'(EW_RGY), 8'b100);
    step(0, 0, 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
